pipelined_cpu_core: RTL and testbench
=====================================

Name: pipelined_cpu_core

Overview:
- Parametrised two-stage (fetch / execute) successor to the team's single-cycle core.
- Keeps the 4-bit-opcode, three-register-field instruction format, the zero-flag branch scheme (BRZ/BRNZ/JMP) and immediate moves.
- Adds:
  - configurable data, register-address and PC widths;
  - an instruction-fetch valid handshake with stall;
  - a registered instruction stage with branch flush;
  - r0 hardwired to zero;
  - shift and compare ops;
  - a HALT state.
- Sits between the instruction memory and the debug/test harness.

Parameters:
- DATA_W, 32, datapath and register width.
- RA_W, 5, register address width; register count 2**RA_W.
- PC_W, 32, program counter width (word addressed).
- RESET_PC, 0, PC value after reset.
- Derived: INSTR_W = 4 + 3*RA_W (19 at defaults).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- IMEM_ADDR  out  PC_W  fetch address (equals PC).
- IMEM_REQ  out  1  fetch request.
- IMEM_DATA  in  INSTR_W  fetched instruction.
- IMEM_VALID  in  1  IMEM_DATA valid this cycle.
- HALTED  out  1  core stopped by HALT.
- ZERO_FLAG  out  1  registered zero flag.
- RETIRE  out  1  one-cycle pulse per executed instruction.
- DBG_RADDR  in  RA_W  debug register select.
- DBG_RDATA  out  DATA_W  combinational read of the selected register (r0 reads 0).

Behaviour:
- Instruction fields:
  - op = [INSTR_W-1 -: 4]
  - rd = next RA_W bits
  - rs1 = next RA_W bits
  - rs2 = low RA_W bits
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs1 op rs2.
  - 5 SLT: signed compare, result 1 or 0.
  - 6 SHL, 7 SHR (logical): shift amount = low $clog2(DATA_W) bits of the rs2 value.
  - 8 ADDI: rd = rs1 + sext(rs2 field).
  - 9 MOVI: rd = sext({rs1,rs2}), 2*RA_W-bit immediate.
  - 10 BRZ, 11 BRNZ, 12 JMP: offset = sext({rd,rs1,rs2}) to PC_W.
  - 13, 14 NOP.
  - 15 HALT.
- Arithmetic is modulo 2**DATA_W. PC arithmetic is modulo 2**PC_W (wraps). No overflow flags.
- Reset, synchronous, on any CLK edge with RESET=1:
  - PC=RESET_PC, IR_VALID=0, ZERO_FLAG=0, HALTED=0, RETIRE=0.
  - All registers are 0. Reset overrides every other event, including mid-stall and mid-branch.
- Control states: RUN, HALT.
- Fetch (RUN only):
  - IMEM_REQ=1 and IMEM_ADDR=PC.
  - On an edge with IMEM_VALID=1: IR<=IMEM_DATA, IR_PC<=PC, IR_VALID<=1, PC<=PC+1.
  - On an edge with IMEM_VALID=0: PC holds and IR_VALID<=0 (bubble).
- Execute:
  - When IR_VALID=1, IR is decoded combinationally.
  - Register file is read combinationally.
  - Results commit at the next edge, and RETIRE=1 for that cycle.
  - Latency is 1 fetch edge plus 1 execute edge. Sustained throughput is 1 instruction per cycle with no stalls.
- Register writes (ops 0-9):
  - The register write and the ZERO_FLAG update (flag = written value == 0) occur at the same edge.
  - Writes to r0 are discarded, but ZERO_FLAG still updates from the computed value.
  - Branches, NOP and HALT leave registers and the flag unchanged.
- No data hazards:
  - The write lands at the edge before the following instruction executes.
  - The flag read by a branch is the one left by the previous register-writing instruction.
- Taken branch (BRZ with flag=1, BRNZ with flag=0, JMP always):
  - PC<=IR_PC+offset.
  - The instruction fetched at the same edge is discarded (IR_VALID<=0, never retires): one-bubble penalty.
  - A not-taken branch retires with no penalty.
- HALT:
  - Retires (RETIRE=1). At the same edge: state<=HALT, HALTED<=1, IR_VALID<=0, concurrent fetch discarded, PC frozen.
  - In HALT: IMEM_REQ=0, no execution, RETIRE=0. Only RESET leaves HALT.
- IMEM_DATA is ignored whenever IMEM_REQ=0 or IMEM_VALID=0.

Test Plan:
1. RESET high 2 cycles then low, IMEM_VALID=1 -> first cycle: IMEM_ADDR=0, IMEM_REQ=1, HALTED=0, ZERO_FLAG=0, RETIRE=0; all DBG_RDATA=0.
2. Program MOVI r1,5; MOVI r2,-3; ADD r3,r1,r2; SUB r4,r1,r1 -> r3=2 with ZERO_FLAG=0, then r4=0 with ZERO_FLAG=1; RETIRE high for 4 consecutive cycles starting cycle 2.
3. Flag=1, BRZ +3 at address 4 -> next IMEM_ADDR=7; instruction at 5 does not retire; instruction at 7 executes. Same case with BRNZ -> no redirect, no bubble.
4. IMEM_VALID low for 3 cycles mid-program -> IMEM_ADDR stable, RETIRE=0 for the drained cycles, registers unchanged; resumes at the same address with correct results.
5. MOVI r0,7 then ADDI r5,r0,-1 -> r0 reads 0, r5=0xFFFFFFFF. SHL r6,r5,r1 (r1=5) -> 0xFFFFFFE0. SLT r7,r5,r1 -> 1.
6. HALT at address 9 -> HALTED=1 after the next edge, IMEM_REQ=0, IMEM_ADDR frozen for 10 cycles. RESET pulse -> restart at RESET_PC with registers cleared. Repeat reset asserted mid-taken-branch -> PC=RESET_PC, no retire.

Source files
------------

// File: rtl/pipelined_cpu_core.sv
// Two-stage (fetch / execute) core with a registered instruction stage, branch flush and HALT.
// Instruction: {op[3:0], rd, rs1, rs2}; r0 reads as zero and ignores writes.
module pipelined_cpu_core #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned INSTR_W = 4 + 3 * RA_W
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               IMEM_VALID,
  output logic               HALTED,
  output logic               ZERO_FLAG,
  output logic               RETIRE,
  input  logic [RA_W-1:0]    DBG_RADDR,
  output logic [DATA_W-1:0]  DBG_RDATA
);

  localparam int unsigned NREG = 2 ** RA_W;
  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSlt  = 4'd5,
    OpShl  = 4'd6,
    OpShr  = 4'd7,
    OpAddi = 4'd8,
    OpMovi = 4'd9,
    OpBrz  = 4'd10,
    OpBrnz = 4'd11,
    OpJmp  = 4'd12,
    OpNop0 = 4'd13,
    OpNop1 = 4'd14,
    OpHalt = 4'd15
  } op_e;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [PC_W-1:0]     ir_pc_q;
  logic                ir_valid_q;
  logic                zero_q;
  logic                retire_q;
  logic [DATA_W-1:0]   regs_q [NREG];

  op_e                 op;
  logic [RA_W-1:0]     rd_f;
  logic [RA_W-1:0]     rs1_f;
  logic [RA_W-1:0]     rs2_f;
  logic [DATA_W-1:0]   rs1_val;
  logic [DATA_W-1:0]   rs2_val;
  logic [DATA_W-1:0]   imm_addi;
  logic [DATA_W-1:0]   imm_movi;
  logic [PC_W-1:0]     br_offset;
  logic [DATA_W-1:0]   alu_res;
  logic                exec;
  logic                wr_en;
  logic                br_taken;
  logic                halt_exec;

  // Field extraction and operand read
  always_comb begin
    op        = op_e'(ir_q[INSTR_W-1 -: 4]);
    rd_f      = ir_q[3*RA_W-1 -: RA_W];
    rs1_f     = ir_q[2*RA_W-1 -: RA_W];
    rs2_f     = ir_q[RA_W-1:0];
    rs1_val   = (rs1_f == '0) ? '0 : regs_q[rs1_f];
    rs2_val   = (rs2_f == '0) ? '0 : regs_q[rs2_f];
    imm_addi  = {{(DATA_W-RA_W){rs2_f[RA_W-1]}}, rs2_f};
    imm_movi  = {{(DATA_W-2*RA_W){ir_q[2*RA_W-1]}}, ir_q[2*RA_W-1:0]};
    br_offset = {{(PC_W-3*RA_W){ir_q[3*RA_W-1]}}, ir_q[3*RA_W-1:0]};
    exec      = ir_valid_q && (state_q == StRun);
  end

  // Execute-stage decode
  always_comb begin
    alu_res   = '0;
    wr_en     = 1'b0;
    br_taken  = 1'b0;
    halt_exec = 1'b0;
    if (exec) begin
      unique case (op)
        OpAdd:  begin alu_res = rs1_val + rs2_val; wr_en = 1'b1; end
        OpSub:  begin alu_res = rs1_val - rs2_val; wr_en = 1'b1; end
        OpAnd:  begin alu_res = rs1_val & rs2_val; wr_en = 1'b1; end
        OpOr:   begin alu_res = rs1_val | rs2_val; wr_en = 1'b1; end
        OpXor:  begin alu_res = rs1_val ^ rs2_val; wr_en = 1'b1; end
        OpSlt:  begin
          alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
          wr_en   = 1'b1;
        end
        OpShl:  begin alu_res = rs1_val << rs2_val[SH_W-1:0]; wr_en = 1'b1; end
        OpShr:  begin alu_res = rs1_val >> rs2_val[SH_W-1:0]; wr_en = 1'b1; end
        OpAddi: begin alu_res = rs1_val + imm_addi; wr_en = 1'b1; end
        OpMovi: begin alu_res = imm_movi; wr_en = 1'b1; end
        OpBrz:  br_taken = zero_q;
        OpBrnz: br_taken = ~zero_q;
        OpJmp:  br_taken = 1'b1;
        OpNop0, OpNop1: ;
        OpHalt: halt_exec = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StRun;
      pc_q       <= PC_W'(RESET_PC);
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      zero_q     <= 1'b0;
      retire_q   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      retire_q <= exec;
      if (wr_en) begin
        zero_q <= (alu_res == '0);
        if (rd_f != '0) begin
          regs_q[rd_f] <= alu_res;
        end
      end
      if (state_q == StRun) begin
        // Redirects and HALT squash whatever is fetched at the same edge
        if (halt_exec) begin
          state_q    <= StHalt;
          ir_valid_q <= 1'b0;
        end else if (br_taken) begin
          pc_q       <= ir_pc_q + br_offset;
          ir_valid_q <= 1'b0;
        end else if (IMEM_VALID) begin
          ir_q       <= IMEM_DATA;
          ir_pc_q    <= pc_q;
          ir_valid_q <= 1'b1;
          pc_q       <= pc_q + PC_W'(1);
        end else begin
          ir_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    IMEM_ADDR = pc_q;
    IMEM_REQ  = (state_q == StRun);
    HALTED    = (state_q == StHalt);
    ZERO_FLAG = zero_q;
    RETIRE    = retire_q;
    DBG_RDATA = (DBG_RADDR == '0) ? '0 : regs_q[DBG_RADDR];
  end

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Directed and random programs checked against an instruction-level reference model.
module tb_pipelined_cpu_core;

  logic        CLK;
  logic        RESET;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic [18:0] IMEM_DATA;
  logic        IMEM_VALID;
  logic        HALTED;
  logic        ZERO_FLAG;
  logic        RETIRE;
  logic [4:0]  DBG_RADDR;
  logic [31:0] DBG_RDATA;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [18:0] mem [64];
  logic [31:0] m_reg [32];
  logic        m_flag;
  logic [31:0] m_pc;
  logic        m_halt;

  pipelined_cpu_core dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_DATA  (IMEM_DATA),
    .IMEM_VALID (IMEM_VALID),
    .HALTED     (HALTED),
    .ZERO_FLAG  (ZERO_FLAG),
    .RETIRE     (RETIRE),
    .DBG_RADDR  (DBG_RADDR),
    .DBG_RDATA  (DBG_RDATA)
  );

  assign IMEM_DATA = mem[IMEM_ADDR[5:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [18:0] enc(input int op, input int rd, input int rs1, input int rs2);
    logic [3:0] o;
    logic [4:0] a, b, c;
    o = 4'(op);
    a = 5'(rd);
    b = 5'(rs1);
    c = 5'(rs2);
    return {o, a, b, c};
  endfunction

  function automatic logic [18:0] movi(input int rd, input int imm);
    logic [9:0] v;
    v = 10'(imm);
    return enc(9, rd, int'(v[9:5]), int'(v[4:0]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = enc(15, 0, 0, 0);
  endtask

  task automatic iss_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_flag = 1'b0;
    m_pc   = '0;
    m_halt = 1'b0;
  endtask

  // Architectural model: executes one instruction at m_pc
  task automatic iss_step(output logic [4:0] wrd, output bit wr);
    logic [18:0] ins;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, res, off, this_pc;
    ins = mem[m_pc[5:0]];
    op  = ins[18:15];
    rd  = ins[14:10];
    rs1 = ins[9:5];
    rs2 = ins[4:0];
    a   = m_reg[rs1];
    b   = m_reg[rs2];
    off = {{17{ins[14]}}, ins[14:0]};
    res = '0;
    wr  = 1'b1;
    this_pc = m_pc;
    m_pc = m_pc + 32'd1;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  res = a << b[4:0];
      4'd7:  res = a >> b[4:0];
      4'd8:  res = a + {{27{rs2[4]}}, rs2};
      4'd9:  res = {{22{rs1[4]}}, rs1, rs2};
      4'd10: begin wr = 1'b0; if (m_flag) m_pc = this_pc + off; end
      4'd11: begin wr = 1'b0; if (!m_flag) m_pc = this_pc + off; end
      4'd12: begin wr = 1'b0; m_pc = this_pc + off; end
      4'd15: begin wr = 1'b0; m_halt = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_flag = (res == 32'd0);
      if (rd != 5'd0) m_reg[rd] = res;
    end
    wrd = rd;
  endtask

  task automatic apply_reset(input int n);
    RESET = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
    RESET = 1'b0;
    iss_reset();
    cyc = 0;
  endtask

  // Advance one clock; on every retirement step the model and compare the written register
  task automatic cycle();
    logic [4:0] rd;
    bit wr;
    @(posedge CLK);
    #1;
    cyc++;
    if (RETIRE === 1'b1) begin
      iss_step(rd, wr);
      DBG_RADDR = rd;
      #1;
      if (wr) check("retire_rd", DBG_RDATA, m_reg[rd]);
      check("retire_flag", 32'(ZERO_FLAG), 32'(m_flag));
    end else begin
      #1;
    end
    check("halted", 32'(HALTED), 32'(m_halt));
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      DBG_RADDR = 5'(i);
      #1;
      check(tag, DBG_RDATA, m_reg[i]);
    end
  endtask

  task automatic peek(input string tag, input int r, input logic [31:0] exp);
    DBG_RADDR = 5'(r);
    #1;
    check(tag, DBG_RDATA, exp);
  endtask

  initial begin
    logic [31:0] exp_ret;
    int n;
    RESET      = 1'b1;
    IMEM_VALID = 1'b1;
    DBG_RADDR  = '0;
    iss_reset();

    // Program A: moves, add/sub, taken BRZ, untaken BRNZ, HALT at 9
    clear_mem();
    mem[0] = movi(1, 5);
    mem[1] = movi(2, -3);
    mem[2] = enc(0, 3, 1, 2);
    mem[3] = enc(1, 4, 1, 1);
    mem[4] = enc(10, 0, 0, 3);
    mem[5] = movi(6, 21);
    mem[6] = movi(6, 22);
    mem[7] = enc(11, 0, 0, 5);
    mem[8] = enc(0, 7, 3, 3);
    mem[9] = enc(15, 0, 0, 0);
    apply_reset(2);
    check("rst_addr", IMEM_ADDR, 32'd0);
    check("rst_req", 32'(IMEM_REQ), 32'd1);
    check("rst_halted", 32'(HALTED), 32'd0);
    check("rst_zero", 32'(ZERO_FLAG), 32'd0);
    check("rst_retire", 32'(RETIRE), 32'd0);
    peek("rst_r1", 1, 32'd0);
    exp_ret = 32'h0000_077C;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      check("a_retire", 32'(RETIRE), 32'(exp_ret[c]));
      if (c == 6) check("a_brz_target", IMEM_ADDR, 32'd7);
      if (c >= 10) begin
        check("a_halted", 32'(HALTED), 32'd1);
        check("a_req", 32'(IMEM_REQ), 32'd0);
        check("a_addr_frozen", IMEM_ADDR, 32'd10);
      end
    end
    peek("a_r3", 3, 32'd2);
    peek("a_r6_squashed", 6, 32'd0);
    peek("a_r7", 7, 32'd4);
    check_all_regs("a_regs");

    // Program B: r0 discard, ADDI/SHL/SLT, three-cycle fetch stall
    clear_mem();
    mem[0] = movi(1, 5);
    mem[1] = movi(0, 7);
    mem[2] = enc(8, 5, 0, 31);
    mem[3] = enc(6, 6, 5, 1);
    mem[4] = enc(5, 7, 5, 1);
    mem[5] = enc(0, 2, 1, 1);
    mem[6] = enc(15, 0, 0, 0);
    IMEM_VALID = 1'b1;
    apply_reset(2);
    exp_ret = 32'h0000_0F1C;
    for (int c = 1; c <= 16; c++) begin
      cycle();
      check("b_retire", 32'(RETIRE), 32'(exp_ret[c]));
      if (c >= 4 && c <= 6) check("b_stall_addr", IMEM_ADDR, 32'd3);
      if (c == 7) check("b_resume_addr", IMEM_ADDR, 32'd4);
      if (c == 3) IMEM_VALID = 1'b0;
      if (c == 6) IMEM_VALID = 1'b1;
    end
    peek("b_r0", 0, 32'd0);
    peek("b_r5", 5, 32'hFFFF_FFFF);
    peek("b_r6", 6, 32'hFFFF_FFE0);
    peek("b_r7", 7, 32'd1);
    peek("b_r2", 2, 32'd10);
    check_all_regs("b_regs");

    // Reset out of HALT clears everything
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 32; i++) begin
      DBG_RADDR = 5'(i);
      #1;
      check("halt_rst_reg", DBG_RDATA, 32'd0);
    end
    check("halt_rst_halted", 32'(HALTED), 32'd0);
    check("halt_rst_addr", IMEM_ADDR, 32'd0);
    check("halt_rst_req", 32'(IMEM_REQ), 32'd1);

    // Reset while a taken BRZ is executing
    clear_mem();
    mem[0] = movi(1, 5);
    mem[1] = movi(2, -3);
    mem[2] = enc(0, 3, 1, 2);
    mem[3] = enc(1, 4, 1, 1);
    mem[4] = enc(10, 0, 0, 3);
    apply_reset(1);
    repeat (5) cycle();
    check("mid_flag_before", 32'(ZERO_FLAG), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_addr", IMEM_ADDR, 32'd0);
    check("mid_retire", 32'(RETIRE), 32'd0);
    check("mid_zero", 32'(ZERO_FLAG), 32'd0);
    check("mid_halted", 32'(HALTED), 32'd0);
    peek("mid_r1", 1, 32'd0);

    // Random forward-branching programs with random fetch stalls
    for (int p = 0; p < 5; p++) begin
      clear_mem();
      for (int i = 0; i < 40; i++) begin
        int op;
        op = int'($urandom_range(0, 14));
        if (op >= 10 && op <= 12) mem[i] = enc(op, 0, 0, int'($urandom_range(1, 4)));
        else if (op == 8) mem[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                       int'($urandom_range(0, 31)));
        else if (op == 9) mem[i] = movi(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)));
        else mem[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)));
      end
      IMEM_VALID = 1'b1;
      apply_reset(2);
      n = 0;
      while (HALTED !== 1'b1 && n < 400) begin
        IMEM_VALID = ($urandom_range(0, 3) != 0);
        cycle();
        n++;
      end
      check("rand_halted", 32'(HALTED), 32'd1);
      check_all_regs("rand_regs");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
